// File: rtl/alu_uvm_pkg.sv
// Shared types for the ALU issue path.
//   alu_mode_e        : command mode (IDLE, A, B01, B11), encoded 0..3
//   alu_cmd_t         : packed command {mode, op, a, b, tag} as stored in the issue FIFO
//   alu_issue_state_e : issue FSM states
//   mode_has_a/b      : a_en / b_en decode for a mode
package alu_uvm_pkg;

   localparam int ALU_TAG_W = 2;

   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_A    = 2'd1,
      MODE_B01  = 2'd2,
      MODE_B11  = 2'd3
   } alu_mode_e;

   typedef struct packed {
      alu_mode_e              mode;
      logic [2:0]             op;
      logic signed [4:0]      a;
      logic signed [4:0]      b;
      logic [ALU_TAG_W-1:0]   tag;
   } alu_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } alu_issue_state_e;

   function automatic logic mode_has_a(input alu_mode_e m);
      return (m == MODE_A) || (m == MODE_B11);
   endfunction

   function automatic logic mode_has_b(input alu_mode_e m);
      return (m == MODE_B01) || (m == MODE_B11);
   endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO of alu_cmd_t with circular pointers and an occupancy counter.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   push, push_data     : write request and data (ignored when full)
//   pop                 : read request (ignored when empty); head advances next cycle
//   head                : entry at the read pointer
//   full, empty, count  : occupancy status, count in 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_issue_fifo
   import alu_uvm_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  alu_cmd_t                 push_data,
   input  logic                     pop,
   output alu_cmd_t                 head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   alu_cmd_t         mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue queue in front of the 6-bit ALU. Buffers commands in a FIFO, drives one
// command at a time onto the ALU pins, samples C ALU_LAT cycles after the issue
// cycle and returns it with the command tag.
// Ports:
//   clk, rst                              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready                   : command handshake
//   cmd_mode, cmd_op, cmd_a, cmd_b, cmd_tag : command fields
//   ALU_en, a_en, b_en, a_op, b_op, A, B  : ALU pins, non-zero only in the issue cycle
//   C                                     : ALU result
//   rsp_valid/rsp_ready                   : response handshake
//   rsp_c, rsp_tag, rsp_mode              : captured result and command identity
//   busy                                  : FIFO non-empty or a command in flight
// Build option: ALU_ISSUE_PIPE_EN lets HOLD hand straight over to ISSUE on the
// response handshake when another command is queued.
//
// state | meaning
// IDLE  | waiting for a queued command; pops the head when one exists
// ISSUE | single cycle driving the ALU pins; loads the latency timer
// WAIT  | timer counting down; C sampled on terminal count
// HOLD  | response presented until rsp_ready
module alu_issue_queue
   import alu_uvm_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1,
   parameter int TAG_W   = ALU_TAG_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_mode,
   input  logic [2:0]          cmd_op,
   input  logic signed [4:0]   cmd_a,
   input  logic signed [4:0]   cmd_b,
   input  logic [TAG_W-1:0]    cmd_tag,
   output logic                ALU_en,
   output logic                a_en,
   output logic                b_en,
   output logic [2:0]          a_op,
   output logic [1:0]          b_op,
   output logic signed [4:0]   A,
   output logic signed [4:0]   B,
   input  logic signed [5:0]   C,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic signed [5:0]   rsp_c,
   output logic [TAG_W-1:0]    rsp_tag,
   output logic [1:0]          rsp_mode,
   output logic                busy
);

   localparam int                CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CNT_W-1:0]  LAT_INIT = CNT_W'(ALU_LAT - 1);

   if (TAG_W != ALU_TAG_W) begin : g_tag_w_check
      $error("alu_issue_queue: TAG_W must equal alu_uvm_pkg::ALU_TAG_W");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("alu_issue_queue: DEPTH must be a power of two, at least 2");
   end
   if (ALU_LAT < 1) begin : g_lat_check
      $error("alu_issue_queue: ALU_LAT must be at least 1");
   end

   alu_issue_state_e       state;
   alu_issue_state_e       state_d;
   alu_cmd_t               issue_q;
   alu_cmd_t               push_data;
   alu_cmd_t               fifo_head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   push;
   logic                   pop;
   logic                   capture;
   logic [CNT_W-1:0]       cnt;

   // No pass-through: a full FIFO refuses even when a pop happens this cycle.
   assign cmd_ready = !rst && !fifo_full;
   assign push      = cmd_valid && cmd_ready;
   assign busy      = (fifo_count != '0) || (state != ST_IDLE);

   always_comb begin
      push_data      = '0;
      push_data.mode = alu_mode_e'(cmd_mode);
      push_data.op   = cmd_op;
      push_data.a    = cmd_a;
      push_data.b    = cmd_b;
      push_data.tag  = cmd_tag;
   end

   alu_issue_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d = state;
      pop     = 1'b0;
      capture = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               capture = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (rsp_ready) begin
`ifdef ALU_ISSUE_PIPE_EN
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_IDLE;
               end
`else
               state_d = ST_IDLE;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ALU pins are live only during ISSUE; nothing is held between commands.
   always_comb begin
      ALU_en = 1'b0;
      a_en   = 1'b0;
      b_en   = 1'b0;
      a_op   = '0;
      b_op   = '0;
      A      = '0;
      B      = '0;
      if (state == ST_ISSUE) begin
         ALU_en = 1'b1;
         a_en   = mode_has_a(issue_q.mode);
         b_en   = mode_has_b(issue_q.mode);
         a_op   = (issue_q.mode == MODE_A) ? issue_q.op : 3'd0;
         b_op   = mode_has_b(issue_q.mode) ? issue_q.op[1:0] : 2'd0;
         A      = issue_q.a;
         B      = issue_q.b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         issue_q   <= '0;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_c     <= '0;
         rsp_tag   <= '0;
         rsp_mode  <= '0;
      end else begin
         state <= state_d;
         if (pop) begin
            issue_q <= fifo_head;
         end
         // Timer loaded in ISSUE so terminal count lands ALU_LAT cycles after it.
         if (state == ST_ISSUE) begin
            cnt <= LAT_INIT;
         end else if ((state == ST_WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (capture) begin
            rsp_valid <= 1'b1;
            rsp_c     <= C;
            rsp_tag   <= issue_q.tag;
            rsp_mode  <= issue_q.mode;
         end else if ((state == ST_HOLD) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && capture) begin
         assert (!$isunknown(C))
            else $error("alu_issue_queue: C is X/Z at the sample edge");
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
   import alu_uvm_pkg::*;

   localparam int DEPTH = 4;
   localparam int LAT   = 3;
   localparam int TW    = 2;
`ifdef ALU_ISSUE_PIPE_EN
   localparam int PERIOD = LAT + 2;
`else
   localparam int PERIOD = LAT + 3;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_mode;
   logic [2:0]        cmd_op;
   logic [4:0]        cmd_a;
   logic [4:0]        cmd_b;
   logic [TW-1:0]     cmd_tag;
   logic              ALU_en, a_en, b_en;
   logic [2:0]        a_op;
   logic [1:0]        b_op;
   logic [4:0]        A, B;
   logic signed [5:0] C;
   logic              rsp_valid;
   logic              rsp_ready;
   logic signed [5:0] rsp_c;
   logic [TW-1:0]     rsp_tag;
   logic [1:0]        rsp_mode;
   logic              busy;

   alu_issue_queue #(.DEPTH(DEPTH), .ALU_LAT(LAT), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
      .ALU_en(ALU_en), .a_en(a_en), .b_en(b_en), .a_op(a_op), .b_op(b_op),
      .A(A), .B(B), .C(C),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
      .rsp_tag(rsp_tag), .rsp_mode(rsp_mode), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { int mode; int op; int a; int b; int tag; int acc; } cmd_s;
   typedef struct { int mode; int tag; int sample; } pend_s;

   cmd_s              exp_q[$];
   pend_s             pend_q[$];
   logic signed [5:0] c_hist [int];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_issue = -100;
   int last_hs = -100;
   int prev_sp = -1;
   bit inflight = 0;
   bit rst_prev = 0;
   bit spacing_on = 0;
   bit c_dir_on = 0;
   int rdy_mode = 1;

   task automatic chk(input bit ok, input string name, input int act, input int expv);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Pin image {a_en,b_en,a_op,b_op,A,B} an ALU command should produce.
   function automatic int exp_pins(input int m, input int op, input int a, input int b);
      int ae, be, aop, bop;
      ae  = (m == 1 || m == 3) ? 1 : 0;
      be  = (m >= 2) ? 1 : 0;
      aop = (m == 1) ? op : 0;
      bop = (m >= 2) ? (op % 4) : 0;
      return (ae << 16) | (be << 15) | (aop << 12) | (bop << 10) | ((a & 31) << 5) | (b & 31);
   endfunction

   // Cycle counter and ALU result stimulus.
   initial begin
      C = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (c_dir_on && cyc == last_issue + LAT)          C = -6'sd32;
         else if (c_dir_on && cyc == last_issue + LAT - 1) C = 6'sd31;
         else                                              C = 6'($urandom_range(0, 63));
      end
   end

   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0)      rsp_ready = 1'b0;
         else if (rdy_mode == 1) rsp_ready = 1'b1;
         else                    rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   // Reference model and scoreboard, evaluated once per cycle.
   always @(negedge clk) begin
      cmd_s  ec;
      pend_s ph;
      int    exp_issue;
      int    act_pins;
      c_hist[cyc] = C;
      act_pins = int'({a_en, b_en, a_op, b_op, A, B});

      if (rst_prev) begin
         chk(!rsp_valid, "rst_rsp_valid", int'(rsp_valid), 0);
         chk(busy == 1'b0, "rst_busy", int'(busy), 0);
         chk({rsp_c, rsp_tag, rsp_mode} == '0, "rst_rsp_fields", int'({rsp_c, rsp_tag, rsp_mode}), 0);
      end
      if (rst) chk(!cmd_ready, "rst_cmd_ready", int'(cmd_ready), 0);

      if (ALU_en) begin
         if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_issue", 1, 0);
         end else begin
            ec = exp_q.pop_front();
            chk(act_pins == exp_pins(ec.mode, ec.op, ec.a, ec.b), "issue_pins",
                act_pins, exp_pins(ec.mode, ec.op, ec.a, ec.b));
`ifdef ALU_ISSUE_PIPE_EN
            exp_issue = (ec.acc < last_hs) ? last_hs + 1 : ec.acc + 2;
`else
            exp_issue = ((last_hs > ec.acc) ? last_hs : ec.acc) + 2;
`endif
            chk(cyc == exp_issue, "issue_cycle", cyc, exp_issue);
            if (spacing_on) begin
               if (prev_sp >= 0) chk(cyc - prev_sp == PERIOD, "issue_spacing", cyc - prev_sp, PERIOD);
               prev_sp = cyc;
            end
            pend_q.push_back('{mode: ec.mode, tag: ec.tag, sample: cyc + LAT});
            inflight   = 1;
            last_issue = cyc;
         end
      end else begin
         chk(act_pins == 0, "idle_pins", act_pins, 0);
      end
      if (!spacing_on) prev_sp = -1;

      chk(cmd_ready == (!rst && exp_q.size() < DEPTH), "cmd_ready", int'(cmd_ready),
          int'(!rst && exp_q.size() < DEPTH));
      chk(busy == (exp_q.size() > 0 || inflight), "busy", int'(busy),
          int'(exp_q.size() > 0 || inflight));

      if (cmd_valid && cmd_ready)
         exp_q.push_back('{mode: int'(cmd_mode), op: int'(cmd_op), a: int'(cmd_a),
                           b: int'(cmd_b), tag: int'(cmd_tag), acc: cyc});

      if (pend_q.size() == 0) begin
         chk(!rsp_valid, "stale_rsp", int'(rsp_valid), 0);
      end else begin
         ph = pend_q[0];
         if (cyc == ph.sample + 1)  chk(rsp_valid, "rsp_rise", int'(rsp_valid), 1);
         else if (cyc <= ph.sample) chk(!rsp_valid, "rsp_early", int'(rsp_valid), 0);
         if (rsp_valid) begin
            chk(int'(rsp_tag) == ph.tag, "rsp_tag", int'(rsp_tag), ph.tag);
            chk(int'(rsp_mode) == ph.mode, "rsp_mode", int'(rsp_mode), ph.mode);
            chk(rsp_c == c_hist[ph.sample], "rsp_c", int'(rsp_c), int'(c_hist[ph.sample]));
            if (c_dir_on && cyc == ph.sample + 1)
               chk(rsp_c == -6'sd32, "rsp_c_edge", int'(rsp_c), -32);
            if (rsp_ready) begin
               void'(pend_q.pop_front());
               inflight = 0;
               last_hs  = cyc;
            end
         end
      end

      if (rst) begin
         exp_q.delete();
         pend_q.delete();
         inflight = 0;
         last_hs  = -100;
      end
      rst_prev = rst;
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int m, input int op, input int a, input int b, input int tag);
      bit hs;
      hs = 1'b0;
      cmd_valid = 1'b1;
      cmd_mode  = 2'(m);
      cmd_op    = 3'(op);
      cmd_a     = 5'(a);
      cmd_b     = 5'(b);
      cmd_tag   = TW'(tag);
      for (int i = 0; i < 300 && !hs; i++) begin
         @(negedge clk);
         hs = cmd_ready;
         @(posedge clk);
         #1;
      end
      if (!hs) chk(1'b0, "cmd_timeout", 0, 1);
      cmd_valid = 1'b0;
   endtask

   task automatic send_rand();
      send($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 3));
   endtask

   task automatic wait_idle(input int bound);
      bit done;
      done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         if (!busy && !rsp_valid && pend_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
         else cycles(1);
      end
      chk(done, "drain_timeout", int'(done), 1);
   endtask

   initial begin
      bit found;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_mode = '0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
      cycles(2);
      rst = 1'b0;
      cycles(2);

      // Single mode-A command.
      rdy_mode = 1;
      send(1, 0, 5, 3, 1);
      wait_idle(60);

      // Mode B11 op decode and mode IDLE.
      send(3, 6, -7, 9, 2);
      send(0, 5, 1, 2, 3);
      wait_idle(60);

      // Fill past DEPTH with the response stalled, then release.
      rdy_mode = 0;
      for (int i = 0; i < 5; i++)
         send($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 31),
              $urandom_range(0, 31), i % 4);
      cycles(10);
      rdy_mode = 1;
      wait_idle(200);

      // C changes the cycle before the sample edge.
      c_dir_on = 1;
      send(2, 3, 4, -5, 0);
      send(1, 7, -16, 15, 3);
      wait_idle(100);
      c_dir_on = 0;

      // Back-to-back issue spacing with rsp_ready held high.
      spacing_on = 1;
      for (int i = 0; i < 4; i++) send_rand();
      wait_idle(200);
      spacing_on = 0;

      // Random traffic with random response backpressure.
      rdy_mode = 2;
      for (int i = 0; i < 60; i++) begin
         cycles($urandom_range(0, 2));
         send_rand();
      end
      rdy_mode = 1;
      wait_idle(600);

      // Reset while waiting on the ALU with two commands queued.
      rdy_mode = 0;
      for (int i = 0; i < 3; i++) send_rand();
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (pend_q.size() > 0 && cyc > last_issue && cyc <= last_issue + LAT) found = 1'b1;
         else cycles(1);
      end
      chk(found, "reach_wait", int'(found), 1);
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      rdy_mode = 1;
      cycles(15);
      wait_idle(50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
